// File: rtl/apb_master_bridge.sv
// Bridges a valid/ready command stream onto APB3 setup/access transfers, one at a time,
// and returns each result (read data, slave error, timeout abort) on a valid/ready response stream.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel high, penable low, address phase
// ACCESS | psel and penable high, waiting for pready or timeout
// RESP   | APB idle, rsp_valid high until rsp_ready
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] padr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nx;
    logic              cmd_ready_nx, psel_nx, penable_nx, pwrite_nx;
    logic [ADDR_W-1:0] padr_nx;
    logic [DATA_W-1:0] pwdata_nx, rsp_rdata_nx;
    logic              rsp_valid_nx, rsp_err_nx, rsp_timeout_nx;

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            padr        <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            wait_cnt    <= wait_cnt_nx;
            cmd_ready   <= cmd_ready_nx;
            psel        <= psel_nx;
            penable     <= penable_nx;
            pwrite      <= pwrite_nx;
            padr        <= padr_nx;
            pwdata      <= pwdata_nx;
            rsp_valid   <= rsp_valid_nx;
            rsp_rdata   <= rsp_rdata_nx;
            rsp_err     <= rsp_err_nx;
            rsp_timeout <= rsp_timeout_nx;
        end
    end

    // Every output is computed one cycle ahead so that all of them come straight from flops.
    always_comb begin
        state_nx       = state;
        wait_cnt_nx    = wait_cnt;
        cmd_ready_nx   = cmd_ready;
        psel_nx        = psel;
        penable_nx     = penable;
        pwrite_nx      = pwrite;
        padr_nx        = padr;
        pwdata_nx      = pwdata;
        rsp_valid_nx   = rsp_valid;
        rsp_rdata_nx   = rsp_rdata;
        rsp_err_nx     = rsp_err;
        rsp_timeout_nx = rsp_timeout;

        case (state)
            S_IDLE: begin
                cmd_ready_nx = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    pwrite_nx    = cmd_write;
                    padr_nx      = cmd_addr;
                    pwdata_nx    = cmd_wdata;
                    cmd_ready_nx = 1'b0;
                    psel_nx      = 1'b1;
                    penable_nx   = 1'b0;
                    wait_cnt_nx  = '0;
                    state_nx     = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_nx = 1'b1;
                state_nx   = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    psel_nx        = 1'b0;
                    penable_nx     = 1'b0;
                    rsp_valid_nx   = 1'b1;
                    rsp_rdata_nx   = pwrite ? '0 : prdata;
                    rsp_err_nx     = pslverr;
                    rsp_timeout_nx = 1'b0;
                    state_nx       = S_RESP;
                end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
                    psel_nx        = 1'b0;
                    penable_nx     = 1'b0;
                    rsp_valid_nx   = 1'b1;
                    rsp_rdata_nx   = '0;
                    rsp_err_nx     = 1'b1;
                    rsp_timeout_nx = 1'b1;
                    state_nx       = S_RESP;
                end else if (wait_cnt != CNT_MAX) begin
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nx = 1'b0;
                    cmd_ready_nx = 1'b1;
                    state_nx     = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with TIMEOUT=4 and a small APB memory slave
// whose wait states and error response are set per transfer.
module tb_apb_master_bridge;

    logic        clk = 1'b0;
    logic        preset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [31:0] padr, pwdata, prdata;

    int          n_chk  = 0;
    int          n_fail = 0;

    int          slv_wait;
    logic        slv_err;
    int          wait_left;
    logic [31:0] mem [16];

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .padr(padr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    // Slave: wait count loaded during SETUP, pready once it has run down.
    always @(posedge clk) begin
        if (psel && !penable)
            wait_left <= slv_wait;
        else if (psel && penable && wait_left != 0)
            wait_left <= wait_left - 1;
        if (psel && penable && pready && pwrite)
            mem[padr[3:0]] <= pwdata;
    end

    assign pready  = psel && penable && (wait_left == 0);
    assign prdata  = mem[padr[3:0]];
    assign pslverr = slv_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge after the response handshake.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int waits, input logic err, input int hold,
                        input logic [31:0] exp_rd, input logic exp_err, input logic exp_to,
                        input int exp_acc);
        int acc;
        logic ok;
        chk({tag, " cmd_ready idle"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        slv_wait = waits; slv_err = err;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFFF; cmd_write = ~wr;
        chk({tag, " setup psel/penable"}, {psel, penable, cmd_ready}, 3'b100);
        chk({tag, " setup padr/pwrite"}, {pwrite, padr}, {wr, a});
        acc = 0; ok = 1'b1;
        @(negedge clk);
        while (psel && penable && acc < 50) begin
            acc++;
            if (padr !== a || pwrite !== wr || (wr && pwdata !== d)) ok = 1'b0;
            @(negedge clk);
        end
        chk({tag, " access cycles"}, acc, exp_acc);
        chk({tag, " access stable"}, ok, 1);
        chk({tag, " resp valid, apb idle"}, {rsp_valid, psel, penable, cmd_ready}, 4'b1000);
        chk({tag, " resp rdata"}, rsp_rdata, exp_rd);
        chk({tag, " resp err/timeout"}, {rsp_err, rsp_timeout}, {exp_err, exp_to});
        ok = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || psel !== 1'b0 ||
                rsp_rdata !== exp_rd || rsp_err !== exp_err || rsp_timeout !== exp_to) ok = 1'b0;
        end
        if (hold > 0) chk({tag, " resp held stable"}, ok, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, " after handshake"}, {rsp_valid, cmd_ready, psel}, 3'b010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; slv_wait = 0; slv_err = 1'b0;
        @(negedge clk);
        chk("reset controls", {psel, penable, pwrite, rsp_valid, cmd_ready}, 5'b0);
        chk("reset data", {padr, pwdata}, 64'h0);
        chk("reset rsp", {rsp_rdata, rsp_err, rsp_timeout}, 34'h0);
        @(negedge clk);
        chk("cmd_ready in reset", cmd_ready, 0);
        preset = 1'b0;
        @(negedge clk);
        chk("cmd_ready after release", cmd_ready, 1);

        xfer("wr5",   1'b1, 32'd5, 32'hDEADBEEF, 0, 1'b0, 0, 32'h0,        1'b0, 1'b0, 1);
        xfer("rd5",   1'b0, 32'd5, 32'h0,        0, 1'b0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 1);
        xfer("wr3",   1'b1, 32'd3, 32'h12345678, 0, 1'b0, 0, 32'h0,        1'b0, 1'b0, 1);
        xfer("rd3w3", 1'b0, 32'd3, 32'h0,        3, 1'b0, 0, 32'h12345678, 1'b0, 1'b0, 4);
        xfer("rderr", 1'b0, 32'd5, 32'h0,        0, 1'b1, 0, 32'hDEADBEEF, 1'b1, 1'b0, 1);
        xfer("tmo",   1'b0, 32'd3, 32'h0,       99, 1'b0, 0, 32'h0,        1'b1, 1'b1, 4);
        xfer("aftmo", 1'b0, 32'd3, 32'h0,        1, 1'b0, 0, 32'h12345678, 1'b0, 1'b0, 2);
        xfer("hold5", 1'b0, 32'd5, 32'h0,        0, 1'b0, 5, 32'hDEADBEEF, 1'b0, 1'b0, 1);

        // Reset in the middle of a stalled ACCESS.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'd5; cmd_wdata = 32'hBAD0BAD0; slv_wait = 99;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset access", {psel, penable}, 2'b11);
        #2 preset = 1'b1;
        #1 chk("async reset drop", {psel, penable, rsp_valid, cmd_ready}, 4'b0);
        @(negedge clk);
        preset = 1'b0;
        @(negedge clk);
        chk("cmd_ready after mid reset", cmd_ready, 1);
        xfer("postrst", 1'b0, 32'd5, 32'h0, 0, 1'b0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
